// File: rtl/efpga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// efpga_pkg : shared types and constants for the eFPGA custom-instruction responder
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
package efpga_pkg;

   localparam int EfpgaDataW = 32;

   typedef enum logic [1:0] {
      EFPGA_ADD = 2'd0,
      EFPGA_MUL = 2'd1,
      EFPGA_MAC = 2'd2,
      EFPGA_CLR = 2'd3
   } efpga_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } efpga_state_e;

   function automatic logic uses_mult(input efpga_op_e op);
      return (op == EFPGA_MUL) || (op == EFPGA_MAC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/efpga_seq_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// efpga_seq_mult : radix-2 shift-add unsigned multiplier, one bit per cycle
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
module efpga_seq_mult
   import efpga_pkg::*;
#(
   parameter int MulIter = EfpgaDataW
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [EfpgaDataW-1:0]     a_i,
   input  logic [EfpgaDataW-1:0]     b_i,
   output logic                      valid_o,
   output logic [2*EfpgaDataW-1:0]   product_o
);

   localparam int CntW = (MulIter > 1) ? $clog2(MulIter) : 1;

   logic [2*EfpgaDataW-1:0] mcand_q, mcand_d;
   logic [2*EfpgaDataW-1:0] prod_q, prod_d;
   logic [EfpgaDataW-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    run_q, run_d;
   logic                    valid_q, valid_d;

   always_comb begin
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      valid_d  = 1'b0;
      if (abort_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         mcand_d  = {{EfpgaDataW{1'b0}}, a_i};
         mplier_d = b_i;
         prod_d   = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         // Last iteration: product is complete after this edge.
         if (cnt_q == CntW'(MulIter - 1)) begin
            run_d   = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         valid_q  <= valid_d;
      end
   end

   assign valid_o   = valid_q;
   assign product_o = prod_q;

endmodule
`default_nettype wire

// File: rtl/efpga_accel_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// efpga_accel_responder : hard-logic stand-in for the eFPGA custom-instruction fabric
// Revision              : 1.0 - initial release
// ---------------------------------------------------------------------------
module efpga_accel_responder
   import efpga_pkg::*;
#(
   parameter int          MulIter  = 32,
   parameter logic [63:0] AccReset = 64'h0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [EfpgaDataW-1:0] eFPGA_operand_a_i,
   input  logic [EfpgaDataW-1:0] eFPGA_operand_b_i,
   input  logic                  eFPGA_write_strobe_i,
   input  logic                  eFPGA_en_i,
   input  logic [1:0]            eFPGA_operator_i,
   input  logic [3:0]            eFPGA_delay_i,
   output logic [EfpgaDataW-1:0] eFPGA_result_a_o,
   output logic [EfpgaDataW-1:0] eFPGA_result_b_o,
   output logic [EfpgaDataW-1:0] eFPGA_result_c_o,
   output logic                  eFPGA_fpga_done_o,
   output logic                  busy_o
);

   efpga_state_e            state_q, state_d;
   efpga_op_e               op_q, op_d;
   logic [EfpgaDataW-1:0]   a_q, a_d, b_q, b_d;
   logic [3:0]              delay_q, delay_d, wait_q, wait_d;
   logic [EfpgaDataW-1:0]   res_a_q, res_a_d, res_b_q, res_b_d, res_c_q, res_c_d;
   logic [63:0]             acc_q, acc_d;
   logic [31:0]             cnt_q, cnt_d;

   logic                    w_accept;
   logic                    w_mul_start;
   logic                    w_mul_valid;
   logic                    w_finish;
   logic [63:0]             w_product;
   logic [EfpgaDataW:0]     w_sum;

   assign w_accept    = eFPGA_en_i & eFPGA_write_strobe_i &
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign w_mul_start = w_accept & uses_mult(efpga_op_e'(eFPGA_operator_i));
   assign w_sum       = {1'b0, a_q} + {1'b0, b_q};

   // Multiplier is fed straight from the ports so iteration starts on the accepting edge.
   efpga_seq_mult #(
      .MulIter (MulIter)
   ) u_mult (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (w_mul_start),
      .abort_i   (~eFPGA_en_i),
      .a_i       (eFPGA_operand_a_i),
      .b_i       (eFPGA_operand_b_i),
      .valid_o   (w_mul_valid),
      .product_o (w_product)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      delay_d  = delay_q;
      wait_d   = wait_q;
      res_a_d  = res_a_q;
      res_b_d  = res_b_q;
      res_c_d  = res_c_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      w_finish = 1'b0;

      if (!eFPGA_en_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  state_d = ST_EXEC;
                  op_d    = efpga_op_e'(eFPGA_operator_i);
                  a_d     = eFPGA_operand_a_i;
                  b_d     = eFPGA_operand_b_i;
                  delay_d = eFPGA_delay_i;
               end
            end
            ST_EXEC: w_finish = uses_mult(op_q) ? w_mul_valid : 1'b1;
            ST_WAIT: begin
               if (wait_q <= 4'd1) begin
                  state_d = ST_DONE;
               end else begin
                  wait_d = wait_q - 4'd1;
               end
            end
         endcase
      end

      if (w_finish) begin
         state_d = (delay_q == 4'd0) ? ST_DONE : ST_WAIT;
         wait_d  = delay_q;
         case (op_q)
            EFPGA_ADD: begin
               res_a_d = w_sum[EfpgaDataW-1:0];
               res_b_d = a_q - b_q;
               res_c_d = {{(EfpgaDataW-1){1'b0}}, w_sum[EfpgaDataW]};
            end
            EFPGA_MUL: begin
               res_a_d = w_product[31:0];
               res_b_d = w_product[63:32];
               res_c_d = '0;
            end
            EFPGA_MAC: begin
               acc_d   = acc_q + w_product;
               cnt_d   = cnt_q + 32'd1;
               res_a_d = acc_d[31:0];
               res_b_d = acc_d[63:32];
               res_c_d = cnt_d;
            end
            EFPGA_CLR: begin
               acc_d   = AccReset;
               cnt_d   = '0;
               res_a_d = '0;
               res_b_d = '0;
               res_c_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         op_q    <= EFPGA_ADD;
         a_q     <= '0;
         b_q     <= '0;
         delay_q <= '0;
         wait_q  <= '0;
         res_a_q <= '0;
         res_b_q <= '0;
         res_c_q <= '0;
         acc_q   <= AccReset;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         delay_q <= delay_d;
         wait_q  <= wait_d;
         res_a_q <= res_a_d;
         res_b_q <= res_b_d;
         res_c_q <= res_c_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign eFPGA_result_a_o  = res_a_q;
   assign eFPGA_result_b_o  = res_b_q;
   assign eFPGA_result_c_o  = res_c_q;
   assign eFPGA_fpga_done_o = (state_q == ST_DONE);
   assign busy_o            = (state_q == ST_EXEC) || (state_q == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_efpga_accel_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_efpga_accel_responder : vector table, corner sequences and random ops vs a reference model
// Revision                 : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_efpga_accel_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a_i = '0, b_i = '0;
   logic        strobe = 1'b0, en = 1'b0;
   logic [1:0]  op_i = '0;
   logic [3:0]  delay_i = '0;
   logic [31:0] res_a, res_b, res_c;
   logic        done, busy;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [63:0] m_acc = '0;
   logic [31:0] m_cnt = '0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  d;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] ec;
      int          lat;
   } vec_t;

   vec_t vt[8];

   efpga_accel_responder #(
      .MulIter  (32),
      .AccReset (64'h0)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .eFPGA_operand_a_i    (a_i),
      .eFPGA_operand_b_i    (b_i),
      .eFPGA_write_strobe_i (strobe),
      .eFPGA_en_i           (en),
      .eFPGA_operator_i     (op_i),
      .eFPGA_delay_i        (delay_i),
      .eFPGA_result_a_o     (res_a),
      .eFPGA_result_b_o     (res_b),
      .eFPGA_result_c_o     (res_c),
      .eFPGA_fpga_done_o    (done),
      .busy_o               (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: operator semantics with plain arithmetic; latency = k + delay.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] d, output logic [31:0] ea, output logic [31:0] eb,
                        output logic [31:0] ec, output int elat);
      logic [32:0] s;
      logic [63:0] p;
      s  = {1'b0, a} + {1'b0, b};
      p  = {32'b0, a} * {32'b0, b};
      ea = '0; eb = '0; ec = '0;
      case (op)
         2'd0: begin ea = s[31:0]; eb = a - b; ec = {31'b0, s[32]}; end
         2'd1: begin ea = p[31:0]; eb = p[63:32]; ec = '0; end
         2'd2: begin
            m_acc = m_acc + p;
            m_cnt = m_cnt + 32'd1;
            ea = m_acc[31:0]; eb = m_acc[63:32]; ec = m_cnt;
         end
         default: begin m_acc = '0; m_cnt = '0; end
      endcase
      elat = ((op == 2'd1 || op == 2'd2) ? 33 : 1) + int'(d);
   endtask

   task automatic exec_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] ec, input int elat, input bit inject,
                          input string tag);
      int lat;
      int busy_n;
      @(negedge clk);
      en = 1'b1; strobe = 1'b1; op_i = op; a_i = a; b_i = b; delay_i = d;
      @(posedge clk); #1;
      strobe = 1'b0;
      check({tag, " done cleared on accept"}, 64'(done), 64'd0);
      check({tag, " busy on accept"}, 64'(busy), 64'd1);
      lat    = 0;
      busy_n = busy ? 1 : 0;
      while (!done && lat < 200) begin
         if (inject && (lat == 2 || lat == 6)) begin
            strobe = 1'b1; op_i = 2'd0; a_i = $urandom; b_i = $urandom;
         end else begin
            strobe = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (busy) busy_n++;
      end
      strobe = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " busy cycles"}, 64'(busy_n), 64'(elat));
      check({tag, " result A"}, 64'(res_a), 64'(ea));
      check({tag, " result B"}, 64'(res_b), 64'(eb));
      check({tag, " result C"}, 64'(res_c), 64'(ec));
   endtask

   initial begin
      logic [31:0] ea, eb, ec, ra, rb;
      logic [1:0]  rop;
      logic [3:0]  rd;
      int          elat;
      bit          saw;

      vt[0] = '{2'd0, 32'hFFFF_FFFF, 32'h1,          4'd0,  32'h0,          32'hFFFF_FFFE, 32'h1, 1};
      vt[1] = '{2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd5,  32'h242D_2080, 32'h0B00_EA4E, 32'h0, 38};
      vt[2] = '{2'd2, 32'd2,         32'd3,         4'd0,  32'd6,          32'd0,         32'd1, 33};
      vt[3] = '{2'd2, 32'd2,         32'd3,         4'd0,  32'd12,         32'd0,         32'd2, 33};
      vt[4] = '{2'd2, 32'd2,         32'd3,         4'd0,  32'd18,         32'd0,         32'd3, 33};
      vt[5] = '{2'd3, 32'hAAAA_0000, 32'h5555,      4'd2,  32'd0,          32'd0,         32'd0, 3};
      vt[6] = '{2'd2, 32'd1,         32'd1,         4'd1,  32'd1,          32'd0,         32'd1, 34};
      vt[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 4'd15, 32'd0,          32'd0,         32'd1, 16};

      #12;
      check("reset done", 64'(done), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset A", 64'(res_a), 64'd0);
      check("reset B", 64'(res_b), 64'd0);
      check("reset C", 64'(res_c), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         model(vt[i].op, vt[i].a, vt[i].b, vt[i].d, ea, eb, ec, elat);
         exec_op(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].ea, vt[i].eb, vt[i].ec,
                 vt[i].lat, 1'b0, $sformatf("vec%0d", i));
      end

      // Strobes during EXEC are ignored; result reflects the first operands.
      model(2'd1, 32'd7, 32'd9, 4'd0, ea, eb, ec, elat);
      exec_op(2'd1, 32'd7, 32'd9, 4'd0, 32'd63, 32'd0, 32'd0, 33, 1'b1, "busy strobes");

      // Abort an in-flight MAC by dropping en.
      model(2'd3, 32'd0, 32'd0, 4'd0, ea, eb, ec, elat);
      exec_op(2'd3, 32'd0, 32'd0, 4'd0, ea, eb, ec, elat, 1'b0, "clr before abort");
      @(negedge clk);
      en = 1'b1; strobe = 1'b1; op_i = 2'd2; a_i = 32'd5; b_i = 32'd5; delay_i = 4'd0;
      @(posedge clk); #1;
      strobe = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      saw = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) saw = 1'b1;
      end
      check("abort done never rises", 64'(saw), 64'd0);
      check("abort A untouched", 64'(res_a), 64'd0);
      check("abort C untouched", 64'(res_c), 64'd0);
      model(2'd2, 32'd2, 32'd3, 4'd0, ea, eb, ec, elat);
      exec_op(2'd2, 32'd2, 32'd3, 4'd0, ea, eb, ec, elat, 1'b0, "mac after abort");
      check("mac after abort count", 64'(res_c), 64'd1);

      // Asynchronous reset between clock edges during a MUL.
      @(negedge clk);
      en = 1'b1; strobe = 1'b1; op_i = 2'd1; a_i = 32'hDEAD; b_i = 32'hBEEF; delay_i = 4'd3;
      @(posedge clk); #1;
      strobe = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst done", 64'(done), 64'd0);
      check("async rst A", 64'(res_a), 64'd0);
      check("async rst C", 64'(res_c), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      m_acc = '0;
      m_cnt = '0;
      model(2'd0, 32'd5, 32'd7, 4'd0, ea, eb, ec, elat);
      exec_op(2'd0, 32'd5, 32'd7, 4'd0, 32'd12, 32'hFFFF_FFFE, 32'd0, 1, 1'b0, "add after rst");

      // Random operations, some back-to-back from DONE, some after en drop.
      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
         rd  = 4'($urandom_range(0, 15));
         if (i % 5 == 0) begin
            @(negedge clk);
            en = 1'b0;
            @(posedge clk); #1;
            check($sformatf("rnd%0d en drop done", i), 64'(done), 64'd0);
         end
         model(rop, ra, rb, rd, ea, eb, ec, elat);
         exec_op(rop, ra, rb, rd, ea, eb, ec, elat, (i % 7 == 3), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
